stream_upsizer: RTL and testbench

STREAM_UPSIZER -- requirements
Module: stream_upsizer

---
 rtl/stream_upsizer_if.sv | 30 +++
 rtl/stream_upsizer.sv | 165 ++++++++++++++++
 tb/tb_stream_upsizer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_upsizer_if.sv
// Handshake bundle for stream_upsizer.
//   slave  : the upsizer side (consumes beats, produces packed words)
//   master : the environment side (offers beats, accepts packed words)
// Input side : data_i, valid_i, grant_o, flush_i
// Output side: data_o, count_o, valid_o, grant_i
interface stream_upsizer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RATIO      = 4
);
    localparam int unsigned CNT_W = $clog2(RATIO) + 1;

    logic [DATA_WIDTH-1:0]       data_i;
    logic                        valid_i;
    logic                        grant_o;
    logic                        flush_i;
    logic [DATA_WIDTH*RATIO-1:0] data_o;
    logic [CNT_W-1:0]            count_o;
    logic                        valid_o;
    logic                        grant_i;

    modport slave (
        input  data_i, valid_i, flush_i, grant_i,
        output grant_o, data_o, count_o, valid_o
    );

    modport master (
        output data_i, valid_i, flush_i, grant_i,
        input  grant_o, data_o, count_o, valid_o
    );
endinterface

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow input beats into one wide output word.
// A word is closed when the last lane fills, on flush_i, or after TIMEOUT
// idle cycles with a partial word pending (TIMEOUT=0 disables this).
// Unfilled lanes of a closed word are zero; count_o gives the filled lanes.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : stream_upsizer_if.slave (beat input, word output, handshakes)
module stream_upsizer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RATIO      = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    stream_upsizer_if.slave bus
);
    localparam int unsigned IDX_W     = $clog2(RATIO);
    localparam int unsigned CNT_W     = IDX_W + 1;
    localparam int unsigned IDLE_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned IDLE_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(RATIO - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FILL       = 2'd1,
        CLOSE_WAIT = 2'd2
    } state_t;

    typedef logic [RATIO-1:0][DATA_WIDTH-1:0] lanes_t;

    state_t            state_q, state_n;
    lanes_t            acc_q, acc_n;
    lanes_t            merged;
    lanes_t            out_q, out_n;
    logic [IDX_W-1:0]  acc_cnt_q, acc_cnt_n;
    logic [CNT_W-1:0]  pend_q, pend_n;
    logic [CNT_W-1:0]  count_q, count_n;
    logic [CNT_W-1:0]  fill_cnt;
    logic [IDLE_W-1:0] idle_q, idle_n;
    logic              valid_q, valid_n;
    logic              grant_q, grant_n;
    logic              accept;
    logic              out_free;
    logic              last_beat;
    logic              flush_close;
    logic              tmo_close;
    logic              close;

    // Keep the first n lanes of src, zero the rest.
    function automatic lanes_t mask_lanes(input lanes_t src, input logic [CNT_W-1:0] n);
        lanes_t res;
        res = '0;
        for (int k = 0; k < int'(RATIO); k++) begin
            if (CNT_W'(k) < n) begin
                res[k] = src[k];
            end
        end
        return res;
    endfunction

    // Handshake and close-event decode.
    always_comb begin
        accept   = bus.valid_i & grant_q;
        out_free = ~valid_q | bus.grant_i;
        fill_cnt = CNT_W'(acc_cnt_q) + CNT_W'(accept);

        merged = acc_q;
        if (accept) begin
            merged[acc_cnt_q] = bus.data_i;
        end

        last_beat   = accept && (acc_cnt_q == LAST_LANE);
        flush_close = bus.flush_i && ((acc_cnt_q != '0) || accept);
        tmo_close   = (TIMEOUT != 0) && (state_q == FILL) && !accept &&
                      (idle_q == IDLE_W'(IDLE_LAST));
        close       = (state_q != CLOSE_WAIT) && (last_beat || flush_close || tmo_close);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state_q;
        acc_n     = acc_q;
        acc_cnt_n = acc_cnt_q;
        pend_n    = pend_q;
        idle_n    = idle_q;
        out_n     = out_q;
        count_n   = count_q;
        valid_n   = valid_q & ~bus.grant_i;

        case (state_q)
            IDLE, FILL: begin
                if (close) begin
                    idle_n = '0;
                    if (out_free) begin
                        out_n     = mask_lanes(merged, fill_cnt);
                        count_n   = fill_cnt;
                        valid_n   = 1'b1;
                        acc_cnt_n = '0;
                        state_n   = IDLE;
                    end else begin
                        // Output busy: park the closed word (beat included).
                        acc_n   = merged;
                        pend_n  = fill_cnt;
                        state_n = CLOSE_WAIT;
                    end
                end else if (accept) begin
                    acc_n     = merged;
                    acc_cnt_n = acc_cnt_q + 1'b1;
                    idle_n    = '0;
                    state_n   = FILL;
                end else if ((TIMEOUT != 0) && (state_q == FILL)) begin
                    idle_n = idle_q + 1'b1;
                end
            end
            CLOSE_WAIT: begin
                if (out_free) begin
                    out_n     = mask_lanes(acc_q, pend_q);
                    count_n   = pend_q;
                    valid_n   = 1'b1;
                    acc_cnt_n = '0;
                    state_n   = IDLE;
                end
            end
            default: begin
                state_n   = IDLE;
                acc_cnt_n = '0;
                idle_n    = '0;
            end
        endcase

        // Stall input when a parked word exists, or when the next beat would
        // close a word while the output register is still occupied.
        grant_n = (state_n != CLOSE_WAIT) && !((acc_cnt_n == LAST_LANE) && valid_n);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            acc_cnt_q <= '0;
            pend_q    <= '0;
            idle_q    <= '0;
            out_q     <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            grant_q   <= 1'b1;
        end else begin
            state_q   <= state_n;
            acc_q     <= acc_n;
            acc_cnt_q <= acc_cnt_n;
            pend_q    <= pend_n;
            idle_q    <= idle_n;
            out_q     <= out_n;
            count_q   <= count_n;
            valid_q   <= valid_n;
            grant_q   <= grant_n;
        end
    end

    assign bus.data_o  = out_q;
    assign bus.count_o = count_q;
    assign bus.valid_o = valid_q;
    assign bus.grant_o = grant_q;
endmodule

// File: tb/tb_stream_upsizer.sv
// Testbench for stream_upsizer: directed scenarios plus randomized traffic
// checked against a queue-based word-grouping reference model.
module tb_stream_upsizer;
    localparam int unsigned DW  = 32;
    localparam int unsigned R   = 4;
    localparam int unsigned TMO = 16;
    localparam int unsigned OW  = DW * R;

    typedef struct packed {
        logic [OW-1:0] data;
        logic [2:0]    cnt;
    } exp_t;

    logic clk;
    logic rst_n;

    stream_upsizer_if #(.DATA_WIDTH(DW), .RATIO(R)) bus ();

    stream_upsizer #(.DATA_WIDTH(DW), .RATIO(R), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [DW-1:0] grp[$];
    exp_t          expq[$];
    int            idle_cnt = 0;
    logic          hold_prev = 1'b0;
    logic [OW-1:0] prev_data = '0;
    logic [2:0]    prev_cnt = '0;

    task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observe one cycle at the falling edge, update the model, then step past
    // the next rising edge.
    task automatic tick();
        exp_t          e;
        logic          acc;
        logic          cls;
        logic [OW-1:0] w;
        @(negedge clk);
        if (!rst_n) begin
            grp.delete();
            expq.delete();
            idle_cnt  = 0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", OW'(bus.valid_o), OW'(1));
                check("hold_data", bus.data_o, prev_data);
                check("hold_cnt", OW'(bus.count_o), OW'(prev_cnt));
            end
            hold_prev = bus.valid_o && !bus.grant_i;
            prev_data = bus.data_o;
            prev_cnt  = bus.count_o;

            if (bus.valid_o && bus.grant_i) begin
                if (expq.size() == 0) begin
                    check("unexpected_word", OW'(1), OW'(0));
                end else begin
                    e = expq.pop_front();
                    check("word_data", bus.data_o, e.data);
                    check("word_cnt", OW'(bus.count_o), OW'(e.cnt));
                end
            end

            acc = bus.valid_i && bus.grant_o;
            if (acc) grp.push_back(bus.data_i);
            cls = 1'b0;
            if (grp.size() == R) begin
                cls = 1'b1;
            end else if (bus.flush_i && grp.size() > 0) begin
                cls = 1'b1;
            end else if (grp.size() > 0 && !acc) begin
                idle_cnt++;
                if (TMO != 0 && idle_cnt == int'(TMO)) cls = 1'b1;
            end
            if (acc) idle_cnt = 0;
            if (cls) begin
                w = '0;
                for (int k = 0; k < grp.size(); k++) w[k*DW +: DW] = grp[k];
                e.data = w;
                e.cnt  = 3'(grp.size());
                expq.push_back(e);
                grp.delete();
                idle_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        bus.valid_i = 1'b1;
        bus.data_i  = d;
        tick();
        bus.valid_i = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] beats [8];
        logic [OW-1:0] held;
        int n;
        int cyc;
        int bubbles;
        int words;
        int mode;

        bus.data_i  = '0;
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.grant_i = 1'b1;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", OW'(bus.valid_o), OW'(0));
        check("rst_data", bus.data_o, OW'(0));
        check("rst_cnt", OW'(bus.count_o), OW'(0));
        check("rst_grant", OW'(bus.grant_o), OW'(1));
        rst_n = 1'b1;
        tick();

        // Four back-to-back beats make one full word.
        send(32'h11); send(32'h22); send(32'h33); send(32'h44);
        check("full_valid", OW'(bus.valid_o), OW'(1));
        check("full_data", bus.data_o, 128'h00000044_00000033_00000022_00000011);
        check("full_cnt", OW'(bus.count_o), OW'(4));
        tick();

        // Flush closes a partial word; flush with nothing pending is ignored.
        send(32'h11); send(32'h22);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check("flush_valid", OW'(bus.valid_o), OW'(1));
        check("flush_data", bus.data_o, 128'h00000000_00000000_00000022_00000011);
        check("flush_cnt", OW'(bus.count_o), OW'(2));
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check("idle_flush_a", OW'(bus.valid_o), OW'(0));
        tick();
        check("idle_flush_b", OW'(bus.valid_o), OW'(0));

        // Timeout flush after TMO idle cycles.
        send(32'hA); send(32'hB); send(32'hC);
        repeat (TMO - 1) tick();
        check("tmo_early", OW'(bus.valid_o), OW'(0));
        tick();
        check("tmo_valid", OW'(bus.valid_o), OW'(1));
        check("tmo_cnt", OW'(bus.count_o), OW'(3));
        check("tmo_data", bus.data_o, 128'h00000000_0000000C_0000000B_0000000A);
        tick();

        // Backpressure: downstream stalled while 8 beats are offered.
        for (int i = 0; i < 8; i++) beats[i] = 32'h101 + 32'(i);
        bus.grant_i = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 7 && cyc < 30) begin
            bus.valid_i = 1'b1;
            bus.data_i  = beats[n];
            if (bus.grant_o) n++;
            tick();
            cyc++;
        end
        check("bp_accepted7", OW'(n), OW'(7));
        bus.data_i = beats[7];
        check("bp_grant_low", OW'(bus.grant_o), OW'(0));
        check("bp_word1", bus.data_o, {beats[3], beats[2], beats[1], beats[0]});
        held = bus.data_o;
        repeat (3) tick();
        check("bp_grant_still_low", OW'(bus.grant_o), OW'(0));
        check("bp_word1_stable", bus.data_o, held);
        bus.grant_i = 1'b1;
        tick();
        bus.grant_i = 1'b0;
        check("bp_grant_back", OW'(bus.grant_o), OW'(1));
        tick();
        bus.valid_i = 1'b0;
        check("bp_word2_valid", OW'(bus.valid_o), OW'(1));
        check("bp_word2_cnt", OW'(bus.count_o), OW'(4));
        check("bp_word2_data", bus.data_o, {beats[7], beats[6], beats[5], beats[4]});
        bus.grant_i = 1'b1;
        tick();

        // Streaming: 12 beats, no bubbles, 3 words.
        n = 0; cyc = 0; bubbles = 0; words = 0;
        while (n < 12 && cyc < 40) begin
            bus.valid_i = 1'b1;
            bus.data_i  = 32'h200 + 32'(n);
            if (!bus.grant_o) bubbles++;
            else n++;
            tick();
            cyc++;
            if (bus.valid_o) words++;
        end
        bus.valid_i = 1'b0;
        tick();
        if (bus.valid_o) words++;
        check("stream_cycles", OW'(cyc), OW'(12));
        check("stream_bubbles", OW'(bubbles), OW'(0));
        check("stream_words", OW'(words), OW'(3));

        // Reset mid-word discards the partial accumulator.
        send(32'hDEAD); send(32'hBEEF);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", OW'(bus.valid_o), OW'(0));
        check("mid_rst_cnt", OW'(bus.count_o), OW'(0));
        check("mid_rst_grant", OW'(bus.grant_o), OW'(1));
        tick();
        rst_n = 1'b1;
        send(32'h1); send(32'h2); send(32'h3); send(32'h4);
        check("post_rst_data", bus.data_o, 128'h00000004_00000003_00000002_00000001);
        check("post_rst_cnt", OW'(bus.count_o), OW'(4));
        tick();

        // Randomized traffic against the model.
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) mode = int'($urandom_range(0, 2));
            bus.valid_i = ($urandom_range(0, 99) < ((mode == 1) ? 15 : 70));
            bus.data_i  = $urandom;
            bus.flush_i = ($urandom_range(0, 99) < ((mode == 1) ? 2 : 5));
            bus.grant_i = ($urandom_range(0, 99) < ((mode == 2) ? 30 : 80));
            tick();
        end
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.grant_i = 1'b1;
        repeat (40) tick();
        check("drain_words", OW'(expq.size()), OW'(0));
        check("drain_beats", OW'(grp.size()), OW'(0));
        check("drain_valid", OW'(bus.valid_o), OW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
